cpu_out_bcd: RTL and testbench

//  Output stage that sits downstream of the CPU `out` port.
//  - Watches the CPU output register and detects every value change.
//  - Converts the new value, taken as unsigned binary, to packed BCD digits with a

---
 rtl/cpu_out_bcd_if.sv | 28 ++
 rtl/cpu_out_bcd.sv | 108 ++++++++++
 tb/tb_cpu_out_bcd.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_out_bcd_if.sv
// Bus between the CPU output register and the BCD output stage.
// The CPU side drives the binary value; the converter side returns BCD and status.
interface cpu_out_bcd_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
);
  logic [DATA_WIDTH-1:0] in;
  logic [4*DIGITS-1:0]   bcd;
  logic                  valid;
  logic                  busy;
  logic                  update;

  modport master (
    output in,
    input  bcd,
    input  valid,
    input  busy,
    input  update
  );

  modport slave (
    input  in,
    output bcd,
    output valid,
    output busy,
    output update
  );
endinterface

// File: rtl/cpu_out_bcd.sv
// Watches the CPU output value and converts every new value to packed BCD with a
// bit-serial double-dabble engine; the last completed result is held on bcd.
module cpu_out_bcd #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input logic          clk,
  input logic          rst,
  cpu_out_bcd_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] bin_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic [BCD_W-1:0]      scratch_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BCD_W-1:0]      bcd_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  update_q;

  logic [BCD_W-1:0]      scratch_d;
  logic [DATA_WIDTH-1:0] bin_d;
  logic                  trigger;

  // Adds 3 to every nibble that is 5 or more; a nibble tops out at 9+3=12, so no carry.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    logic [BCD_W-1:0] adj;
    adj       = dabble_adjust(scratch_q);
    scratch_d = {adj[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
    bin_d     = {bin_q[DATA_WIDTH-2:0], 1'b0};
    trigger   = (bus.in != last_q) || !valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            bin_q     <= bus.in;
            last_q    <= bus.in;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q    <= scratch_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          update_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd    = bcd_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;
  assign bus.update = update_q;

endmodule

// File: tb/tb_cpu_out_bcd.sv
// Bench for cpu_out_bcd: expected BCD values are queued when a new input is driven
// and popped when the converter strobes update.
module tb_cpu_out_bcd;

  localparam int DW = 16;
  localparam int DG = 5;
  localparam int LAT = DW + 2;  // negedges from driving in to seeing update

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4*DG-1:0] exp_q[$];

  cpu_out_bcd_if #(.DATA_WIDTH(DW), .DIGITS(DG)) bus ();

  cpu_out_bcd #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DG-1:0] to_bcd(input int unsigned v);
    logic [4*DG-1:0] r;
    int unsigned     x;
    r = '0;
    x = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Waits on negedges for update; cycles=-1 when the bound runs out.
  task automatic wait_update(output int cycles, output int busy_cycles);
    cycles = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.update === 1'b1) begin
        cycles = n;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc, bcy;
    logic [4*DG-1:0] e;
    rst = 1'b1;
    bus.in = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.bcd !== '0) begin errors++; $display("FAIL reset_bcd got=%h exp=%h", bus.bcd, 20'h0); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update got=%b exp=0", bus.update); end
    rst = 1'b0;
    exp_q.push_back(to_bcd(0));
    wait_update(cyc, bcy);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL first_latency got=%0d exp=%0d", cyc, LAT); end
    checks++; if (bcy !== DW + 1) begin errors++; $display("FAIL first_busy_cycles got=%0d exp=%0d", bcy, DW + 1); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL first_bcd got=%h exp=%h", bus.bcd, e); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", bus.valid); end
    @(negedge clk);
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL first_update_width got=%b exp=0", bus.update); end
  endtask

  task automatic test_convert(input logic [DW-1:0] v);
    int cyc, bcy;
    logic [4*DG-1:0] e;
    bus.in = v;
    exp_q.push_back(to_bcd(v));
    wait_update(cyc, bcy);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL conv_latency in=%0d got=%0d exp=%0d", v, cyc, LAT); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL conv_bcd in=%0d got=%h exp=%h", v, bus.bcd, e); end
    checks++; if (bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL conv_status in=%0d got valid=%b busy=%b exp valid=1 busy=0", v, bus.valid, bus.busy);
    end
    @(negedge clk);
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL conv_update_width in=%0d got=%b exp=0", v, bus.update); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcy, extra;
    logic [4*DG-1:0] e;
    bus.in = 16'd100;
    exp_q.push_back(to_bcd(100));
    repeat (5) @(negedge clk);
    bus.in = 16'd42;
    exp_q.push_back(to_bcd(42));
    wait_update(cyc, bcy);
    checks++; if (cyc !== LAT - 5) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, LAT - 5); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=%h", bus.bcd, e); end
    wait_update(cyc, bcy);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL b2b_second_spacing got=%0d exp=%0d", cyc, LAT); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=%h", bus.bcd, e); end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.update === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_updates got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int cyc, bcy;
    logic [4*DG-1:0] e;
    bus.in = 16'd777;
    exp_q.push_back(to_bcd(777));
    repeat (9) @(negedge clk);  // sampling edge plus 8 SHIFT edges
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_rst got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.bcd !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got bcd=%h valid=%b busy=%b exp bcd=00000 valid=0 busy=0", bus.bcd, bus.valid, bus.busy);
    end
    rst = 1'b0;
    wait_update(cyc, bcy);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL mid_relatency got=%0d exp=%0d", cyc, LAT); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e || bus.valid !== 1'b1) begin
      errors++; $display("FAIL mid_bcd got=%h valid=%b exp=%h valid=1", bus.bcd, bus.valid, e);
    end
  endtask

  task automatic test_stable();
    int cyc, bcy, upd, bsy, chg;
    logic [4*DG-1:0] e;
    bus.in = 16'd500;
    exp_q.push_back(to_bcd(500));
    wait_update(cyc, bcy);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.bcd !== e) begin errors++; $display("FAIL stable_bcd got=%h exp=%h", bus.bcd, e); end
    upd = 0; bsy = 0; chg = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.update === 1'b1) upd++;
      if (bus.busy === 1'b1) bsy++;
      if (bus.bcd !== e) chg++;
    end
    checks++; if (upd !== 0) begin errors++; $display("FAIL stable_updates got=%0d exp=0", upd); end
    checks++; if (bsy !== 0) begin errors++; $display("FAIL stable_busy got=%0d exp=0", bsy); end
    checks++; if (chg !== 0) begin errors++; $display("FAIL stable_bcd_changes got=%0d exp=0", chg); end
  endtask

  initial begin
    logic [DW-1:0] r;
    bus.in = '0;
    test_reset();
    test_convert(16'd1234);
    test_convert(16'd65535);
    test_convert(16'd9);
    for (int i = 0; i < 4; i++) begin
      r = DW'($urandom_range(0, 65535));
      if (r == bus.in) r = r + 1'b1;
      test_convert(r);
    end
    test_back_to_back();
    test_reset_mid();
    test_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
